sram_coef_sched: RTL and testbench
==================================

# sram_coef_sched

Scheduler that owns the single-port coefficient SRAM of the transposed-form FIR and shares it between two requesters: a coefficient-load channel (host writes) and a per-sample tap sweep. A sweep reads all taps in address order and streams them to the multiply-accumulate datapath. Coefficient writes are accepted only between sweeps. The block sits between the host/config logic and the SRAM instance, and drives every SRAM control pin.

## Interface
Parameters:
- DATA_WIDTH, 16, coefficient width (signed)
- ADDR_DEPTH, 33, number of taps; valid SRAM addresses are 1..ADDR_DEPTH; legal range 1..63

Ports:
- iClk_12M  in  1  clock, rising edge
- iRst  in  1  reset, synchronous, active-high. The SRAM's active-low reset is tied to ~iRst at the integration level.
- iSampleValid  in  1  new input sample; requests one tap sweep
- iCoefValid  in  1  coefficient write request
- oCoefReady  out  1  write request accepted this cycle when high together with iCoefValid
- iCoefAddr  in  6  tap address to write
- iCoefData  in  DATA_WIDTH  signed coefficient to write
- oCsnRam  out  1  SRAM chip select, active low
- oWrnRam  out  1  SRAM 0 = write, 1 = read
- oAddrRam  out  6  SRAM address
- oWrDtRam  out  DATA_WIDTH  SRAM write data
- iRdDtRam  in  DATA_WIDTH  SRAM read data; valid one cycle after the read strobe
- oCoefOut  out  DATA_WIDTH  streamed coefficient; combinational passthrough of iRdDtRam
- oCoefOutValid  out  1  oCoefOut is valid
- oTapIdx  out  6  tap index of oCoefOut
- oSweepDone  out  1  pulse coincident with the last tap of a sweep
- oOverrun  out  1  pulse: sample request dropped
- oAddrErr  out  1  pulse: write to out-of-range address dropped

## Operation
- The state machine has four states: IDLE, WRITE, READ, DRAIN.
- Reset values: state IDLE, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, all valid/pulse outputs 0, oTapIdx=0, pending flag 0.
- **IDLE**
  - If iSampleValid or pending is set, go to READ: clear pending, set tap counter to 1.
  - Otherwise, if iCoefValid and oCoefReady, go to WRITE and register the address and data.
- **oCoefReady** = (state==IDLE) && !iSampleValid && !pending. A sample request always has priority over a write.
- **WRITE** (exactly one cycle)
  - Drive oCsnRam=0, oWrnRam=0, oAddrRam/oWrDtRam = captured values; then return to IDLE.
  - If the captured address is 0 or greater than ADDR_DEPTH, oCsnRam stays 1 and oAddrErr pulses for this cycle.
- **READ**
  - Each cycle drive oCsnRam=0, oWrnRam=1, oAddrRam=counter, then increment the counter.
  - When the counter equals ADDR_DEPTH, go to DRAIN next cycle.
- **DRAIN**
  - oCsnRam=1. The last tap data is delivered.
  - If pending is set, go directly to READ (counter 1, clear pending); else go to IDLE.
- **oCoefOutValid / oTapIdx:** registered copies of (read strobe issued, oAddrRam) from the previous cycle.
- **Pending flag:** set by iSampleValid in any state other than IDLE, or in the cycle READ/DRAIN would itself clear it. If iSampleValid arrives while pending is already set, oOverrun pulses and the request is dropped.
- **Reset mid-operation:** any state returns to IDLE next edge, pending cleared, and no further strobes are issued. A partial sweep is abandoned without oSweepDone.
- **Width rules:**
  - Tap counter is 6 bits; it never exceeds ADDR_DEPTH, so it cannot wrap.
  - Data is passed through unmodified; no arithmetic on DATA_WIDTH.

## Timing
- **Sweep, sample seen at cycle t0:**
  - Read strobes at t1..tN with addresses 1..N (N = ADDR_DEPTH).
  - oCoefOutValid at t2..tN+1; oTapIdx 1..N.
  - oSweepDone at tN+1 (DRAIN).
  - IDLE at tN+2.
  - Sweep occupancy is N+2 cycles including the request cycle.
- **Back-to-back sweep with pending set:** DRAIN at tN+1, next address 1 at tN+2, with no idle gap.
- **Write accepted at t0:** SRAM write strobe at t1, ready again at t2. Maximum write throughput is one per 2 cycles.
- **Sample at t0 while WRITE is active:** it becomes pending, and READ starts at t0+2.
- Strobe-bearing outputs are all registered; no combinational path from inputs to SRAM pins.

## Structure
- Shared package `fir_ram_pkg`:
  - state encoding localparams (IDLE=2'd0, WRITE=2'd1, READ=2'd2, DRAIN=2'd3)
  - SRAM strobe constants: CSN_ON=0, WRN_WR=0, WRN_RD=1
  - address width constant 6
- Single module; no sub-module. The 1-cycle read-valid delay line is inline.

## Test plan
- **Basic sweep:** after reset, preload taps 1..33 with values 100..132; pulse iSampleValid at t0 -> addresses 1..33 at t1..t33; oCoefOut 100..132 with oTapIdx 1..33 at t2..t34; oSweepDone only at t34.
- **Write path:** write addr 5 data -7 -> oCoefReady high at accept; at t1 oCsnRam=0, oWrnRam=0, oAddrRam=5, oWrDtRam=0xFFF9; next sweep returns -7 at tap 5.
- **Priority:** iSampleValid and iCoefValid in the same IDLE cycle -> oCoefReady=0, sweep starts; write accepted at the cycle after oSweepDone+1.
- **Pending/overrun:** sample at t0, second sample at t10, third at t12 -> second sweep starts at t35 with no gap; oOverrun pulses at t12 only.
- **Address error:** write to addr 0 and addr 34 -> oAddrErr pulses in each WRITE cycle, oCsnRam stays 1, memory unchanged.
- **Reset mid-sweep:** assert iRst at t15 of a sweep -> next cycle oCsnRam=1 and all pulses 0; no oSweepDone; a new sample after release gives a full 33-tap sweep.

Source files
------------

// File: rtl/fir_ram_pkg.sv
// Shared constants for the FIR coefficient SRAM scheduler:
// state encoding, SRAM strobe levels and the tap address width.
package fir_ram_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic CSN_ON  = 1'b0;
  localparam logic CSN_OFF = 1'b1;
  localparam logic WRN_WR  = 1'b0;
  localparam logic WRN_RD  = 1'b1;

  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_WRITE = WRITE,
    ST_READ  = READ,
    ST_DRAIN = DRAIN
  } state_t;

  // Tap addresses are 1-based; 0 and anything past the last tap are holes.
  function automatic logic addrOk(
    input logic [ADDR_W-1:0] a,
    input int                depth
  );
    return (a != '0) && (int'(a) <= depth);
  endfunction

endpackage

// File: rtl/sram_coef_sched_if.sv
// Coefficient-write handshake plus the SRAM pin bundle.
// master = scheduler view, slave = host/SRAM view.
interface sram_coef_sched_if #(
  parameter int DATA_WIDTH = 16
);
  import fir_ram_pkg::*;

  logic                  iCoefValid;
  logic                  oCoefReady;
  logic [ADDR_W-1:0]     iCoefAddr;
  logic [DATA_WIDTH-1:0] iCoefData;

  logic                  oCsnRam;
  logic                  oWrnRam;
  logic [ADDR_W-1:0]     oAddrRam;
  logic [DATA_WIDTH-1:0] oWrDtRam;
  logic [DATA_WIDTH-1:0] iRdDtRam;

  modport master (
    input  iCoefValid,
    input  iCoefAddr,
    input  iCoefData,
    input  iRdDtRam,
    output oCoefReady,
    output oCsnRam,
    output oWrnRam,
    output oAddrRam,
    output oWrDtRam
  );

  modport slave (
    output iCoefValid,
    output iCoefAddr,
    output iCoefData,
    output iRdDtRam,
    input  oCoefReady,
    input  oCsnRam,
    input  oWrnRam,
    input  oAddrRam,
    input  oWrDtRam
  );

endinterface

// File: rtl/sram_coef_sched.sv
// Single-port coefficient SRAM scheduler: host writes between
// sweeps, per-sample tap sweeps streamed to the MAC datapath.
module sram_coef_sched
  import fir_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_DEPTH = 33
) (
  input  logic                  iClk_12M,
  input  logic                  iRst,
  input  logic                  iSampleValid,
  sram_coef_sched_if.master     bus,
  output logic [DATA_WIDTH-1:0] oCoefOut,
  output logic                  oCoefOutValid,
  output logic [ADDR_W-1:0]     oTapIdx,
  output logic                  oSweepDone,
  output logic                  oOverrun,
  output logic                  oAddrErr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ADDR_DEPTH);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);

  state_t                state;
  state_t                stateNxt;
  logic                  pend;
  logic                  pendNxt;
  logic                  pendClr;
  logic                  ovr;
  logic [ADDR_W-1:0]     tapCnt;
  logic [ADDR_W-1:0]     tapCntNxt;

  logic                  csnQ;
  logic                  csnNxt;
  logic                  wrnQ;
  logic                  wrnNxt;
  logic [ADDR_W-1:0]     addrQ;
  logic [ADDR_W-1:0]     addrNxt;
  logic [DATA_WIDTH-1:0] wrDtQ;
  logic [DATA_WIDTH-1:0] wrDtNxt;
  logic                  addrErrQ;
  logic                  addrErrNxt;

  logic                  rdStrobe;
  logic                  vldQ;
  logic [ADDR_W-1:0]     tapQ;
  logic                  doneQ;

  assign bus.oCoefReady = (state == ST_IDLE)
                        && !iSampleValid
                        && !pend;

  assign rdStrobe = (csnQ == CSN_ON) && (wrnQ == WRN_RD);

  always_comb begin
    stateNxt   = state;
    tapCntNxt  = tapCnt;
    csnNxt     = CSN_OFF;
    wrnNxt     = WRN_RD;
    addrNxt    = addrQ;
    wrDtNxt    = wrDtQ;
    addrErrNxt = 1'b0;
    pendClr    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iSampleValid || pend) begin
          stateNxt  = ST_READ;
          pendClr   = 1'b1;
          tapCntNxt = FIRST;
          csnNxt    = CSN_ON;
          addrNxt   = FIRST;
        end else if (bus.iCoefValid) begin
          stateNxt = ST_WRITE;
          wrnNxt   = WRN_WR;
          addrNxt  = bus.iCoefAddr;
          wrDtNxt  = bus.iCoefData;
          if (addrOk(bus.iCoefAddr, ADDR_DEPTH)) begin
            csnNxt = CSN_ON;
          end else begin
            addrErrNxt = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        stateNxt = ST_IDLE;
      end
      ST_READ: begin
        if (tapCnt == LAST) begin
          stateNxt = ST_DRAIN;
        end else begin
          csnNxt    = CSN_ON;
          tapCntNxt = tapCnt + 1'b1;
          addrNxt   = tapCnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (pend) begin
          stateNxt  = ST_READ;
          pendClr   = 1'b1;
          tapCntNxt = FIRST;
          csnNxt    = CSN_ON;
          addrNxt   = FIRST;
        end else begin
          stateNxt = ST_IDLE;
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  // DRAIN consumes the pending request in the same cycle it may be
  // re-armed, so a sample there is queued rather than dropped.
  always_comb begin
    ovr     = iSampleValid && pend && (state != ST_DRAIN);
    pendNxt = pend;
    if (iSampleValid && (state != ST_IDLE) && !ovr) begin
      pendNxt = 1'b1;
    end else if (pendClr) begin
      pendNxt = 1'b0;
    end
    oOverrun = ovr && !iRst;
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state    <= ST_IDLE;
      pend     <= 1'b0;
      tapCnt   <= '0;
      csnQ     <= CSN_OFF;
      wrnQ     <= WRN_RD;
      addrQ    <= '0;
      wrDtQ    <= '0;
      addrErrQ <= 1'b0;
      vldQ     <= 1'b0;
      tapQ     <= '0;
      doneQ    <= 1'b0;
    end else begin
      state    <= stateNxt;
      pend     <= pendNxt;
      tapCnt   <= tapCntNxt;
      csnQ     <= csnNxt;
      wrnQ     <= wrnNxt;
      addrQ    <= addrNxt;
      wrDtQ    <= wrDtNxt;
      addrErrQ <= addrErrNxt;
      vldQ     <= rdStrobe;
      tapQ     <= addrQ;
      doneQ    <= rdStrobe && (addrQ == LAST);
    end
  end

  assign bus.oCsnRam  = csnQ;
  assign bus.oWrnRam  = wrnQ;
  assign bus.oAddrRam = addrQ;
  assign bus.oWrDtRam = wrDtQ;

  assign oCoefOut      = bus.iRdDtRam;
  assign oCoefOutValid = vldQ;
  assign oTapIdx       = tapQ;
  assign oSweepDone    = doneQ;
  assign oAddrErr      = addrErrQ;

endmodule

// File: tb/tb_sram_coef_sched.sv
// Bench for sram_coef_sched: SRAM model, event-schedule reference,
// write-vector table, directed corner sequences and random traffic.
module tb_sram_coef_sched;
  import fir_ram_pkg::*;

  localparam int DW   = 16;
  localparam int N    = 33;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          sv;
  logic [DW-1:0] coefOut;
  logic          coefOutValid;
  logic [5:0]    tapIdx;
  logic          sweepDone;
  logic          overrun;
  logic          addrErr;

  sram_coef_sched_if #(.DATA_WIDTH(DW)) bus ();

  sram_coef_sched #(
    .DATA_WIDTH(DW),
    .ADDR_DEPTH(N)
  ) dut (
    .iClk_12M     (clk),
    .iRst         (rst),
    .iSampleValid (sv),
    .bus          (bus.master),
    .oCoefOut     (coefOut),
    .oCoefOutValid(coefOutValid),
    .oTapIdx      (tapIdx),
    .oSweepDone   (sweepDone),
    .oOverrun     (overrun),
    .oAddrErr     (addrErr)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [64];
  logic [DW-1:0] rdQ;
  assign bus.iRdDtRam = rdQ;

  always @(posedge clk) begin
    if (bus.oCsnRam == 1'b0) begin
      if (bus.oWrnRam == 1'b0) ram[bus.oAddrRam] <= bus.oWrDtRam;
      else rdQ <= ram[bus.oAddrRam];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // Expected per-cycle pin schedule, filled in when a request is granted.
  logic          eCsn [MAXC];
  logic          eWrn [MAXC];
  logic [5:0]    eAddr[MAXC];
  logic [DW-1:0] eWd  [MAXC];
  logic          eVld [MAXC];
  logic [5:0]    eTap [MAXC];
  logic [DW-1:0] eDat [MAXC];
  logic          eDone[MAXC];
  logic          eErr [MAXC];
  logic [DW-1:0] mm   [64];
  int busyEnd = -1;
  int drainAt = -1;
  bit pendM = 0;

  bit lastRdy, lastErr, lastCsn;
  int ovrCnt = 0, ovrAt = -1, doneCnt = 0, doneAt = -1;

  task automatic clearFrom(input int from);
    for (int i = from; i < MAXC; i++) begin
      eCsn[i] = 1'b1; eWrn[i] = 1'b1; eAddr[i] = '0; eWd[i] = '0;
      eVld[i] = 1'b0; eTap[i] = '0; eDat[i] = '0;
      eDone[i] = 1'b0; eErr[i] = 1'b0;
    end
  endtask

  task automatic startSweep(input int c);
    for (int k = 1; k <= N; k++) begin
      eCsn[c+k] = 1'b0; eWrn[c+k] = 1'b1; eAddr[c+k] = 6'(k);
      eVld[c+k+1] = 1'b1; eTap[c+k+1] = 6'(k); eDat[c+k+1] = mm[k];
    end
    eDone[c+N+1] = 1'b1;
    drainAt = c + N + 1;
    busyEnd = drainAt;
  endtask

  task automatic acceptWrite(input int c, input logic [5:0] a,
                             input logic [DW-1:0] d);
    busyEnd = c + 1;
    if (a != 0 && int'(a) <= N) begin
      eCsn[c+1] = 1'b0; eWrn[c+1] = 1'b0; eAddr[c+1] = a; eWd[c+1] = d;
      mm[a] = d;
    end else begin
      eErr[c+1] = 1'b1;
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [5:0] a,
                      input logic [DW-1:0] d, input logic r);
    bit idle, eRdy, eOvr;
    sv = s; bus.iCoefValid = v; bus.iCoefAddr = a;
    bus.iCoefData = d; rst = r;
    @(negedge clk);
    lastRdy = bus.oCoefReady; lastErr = addrErr; lastCsn = bus.oCsnRam;
    if (r) begin
      clearFrom(cyc + 1);
      busyEnd = cyc; drainAt = -1; pendM = 0;
    end else begin
      idle = cyc > busyEnd;
      eRdy = idle && !s && !pendM;
      eOvr = s && pendM && (cyc != drainAt);
      chk("ready", bus.oCoefReady, eRdy);
      chk("overrun", overrun, eOvr);
      chk("csn", bus.oCsnRam, eCsn[cyc]);
      if (eCsn[cyc] == 1'b0) begin
        chk("wrn", bus.oWrnRam, eWrn[cyc]);
        chk("addr", bus.oAddrRam, eAddr[cyc]);
        if (eWrn[cyc] == 1'b0) chk("wdata", bus.oWrDtRam, eWd[cyc]);
      end
      chk("addrErr", addrErr, eErr[cyc]);
      chk("valid", coefOutValid, eVld[cyc]);
      if (eVld[cyc]) begin
        chk("tapIdx", tapIdx, eTap[cyc]);
        chk("coef", coefOut, eDat[cyc]);
      end
      chk("done", sweepDone, eDone[cyc]);
      if (overrun) begin ovrCnt++; ovrAt = cyc; end
      if (sweepDone) begin doneCnt++; doneAt = cyc; end
      if (idle) begin
        if (s || pendM) begin startSweep(cyc); pendM = 0; end
        else if (v) acceptWrite(cyc, a, d);
      end else if (cyc == drainAt && pendM) begin
        startSweep(cyc); pendM = s;
      end else if (s && !pendM) begin
        pendM = 1;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idleN(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 6'd0, '0, 0);
  endtask

  typedef struct {
    logic [5:0]    addr;
    logic [DW-1:0] data;
    logic          expErr;
    logic          expCsn;
  } wvec_t;

  wvec_t wv[6];

  initial begin
    int t0, acc;
    int dBefore;
    for (int i = 0; i < 64; i++) begin ram[i] = '0; mm[i] = '0; end
    clearFrom(0);
    sv = 0; rst = 1; bus.iCoefValid = 0;
    bus.iCoefAddr = '0; bus.iCoefData = '0;

    for (int i = 0; i < 3; i++) step(0, 0, 6'd0, '0, 1);

    @(negedge clk);
    chk("rst_csn", bus.oCsnRam, 1'b1);
    chk("rst_wrn", bus.oWrnRam, 1'b1);
    chk("rst_addr", bus.oAddrRam, 6'd0);
    chk("rst_wdata", bus.oWrDtRam, 16'd0);
    chk("rst_valid", coefOutValid, 1'b0);
    chk("rst_tap", tapIdx, 6'd0);
    chk("rst_done", sweepDone, 1'b0);
    chk("rst_err", addrErr, 1'b0);
    chk("rst_ready", bus.oCoefReady, 1'b1);
    @(posedge clk); #1;
    cyc++;

    for (int k = 1; k <= N; k++) begin
      step(0, 1, 6'(k), DW'(99 + k), 0);
      idleN(1);
    end

    t0 = cyc;
    step(1, 0, 6'd0, '0, 0);
    idleN(38);
    chk("basic_done_at", doneAt - t0, N + 1);

    wv[0] = '{6'd5,  16'hFFF9, 1'b0, 1'b0};
    wv[1] = '{6'd0,  16'h1234, 1'b1, 1'b1};
    wv[2] = '{6'd34, 16'h5555, 1'b1, 1'b1};
    wv[3] = '{6'd33, 16'h7FFF, 1'b0, 1'b0};
    wv[4] = '{6'd1,  16'h8000, 1'b0, 1'b0};
    wv[5] = '{6'd63, 16'hAAAA, 1'b1, 1'b1};
    foreach (wv[i]) begin
      step(0, 1, wv[i].addr, wv[i].data, 0);
      chk("wr_ready", lastRdy, 1'b1);
      idleN(1);
      chk("wr_err", lastErr, wv[i].expErr);
      chk("wr_csn", lastCsn, wv[i].expCsn);
    end
    chk("ram0_kept", ram[0], 16'd0);
    chk("ram34_kept", ram[34], 16'd0);
    chk("ram63_kept", ram[63], 16'd0);
    step(1, 0, 6'd0, '0, 0);
    idleN(38);

    step(0, 1, 6'd9, 16'd123, 0);
    step(1, 0, 6'd0, '0, 0);
    idleN(40);

    t0 = cyc;
    acc = -1;
    step(1, 1, 6'd7, 16'h00AA, 0);
    for (int i = 0; i < 100 && acc < 0; i++) begin
      step(0, 1, 6'd7, 16'h00AA, 0);
      if (lastRdy) acc = cyc - 1;
    end
    chk("prio_accept_at", acc - t0, N + 2);
    idleN(2);

    t0 = cyc;
    ovrCnt = 0;
    for (int i = 0; i < 80; i++) begin
      step((i == 0 || i == 10 || i == 12), 0, 6'd0, '0, 0);
    end
    chk("ovr_count", ovrCnt, 1);
    chk("ovr_at", ovrAt - t0, 12);

    dBefore = doneCnt;
    step(1, 0, 6'd0, '0, 0);
    idleN(14);
    step(0, 0, 6'd0, '0, 1);
    idleN(40);
    chk("rst_no_done", doneCnt - dBefore, 0);
    step(1, 0, 6'd0, '0, 0);
    idleN(38);
    chk("post_rst_sweep", doneCnt - dBefore, 1);

    while (cyc < MAXC - 100) begin
      logic r, s, v;
      r = ($urandom_range(0, 399) == 0);
      s = !r && ($urandom_range(0, 14) == 0);
      v = !r && ($urandom_range(0, 2) == 0);
      step(s, v, 6'($urandom_range(0, 40)), DW'($urandom), r);
    end
    idleN(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
